// File: rtl/shift_sub_divider.sv
// Restoring shift/subtract divider, one quotient bit per cycle.
// Define SHIFT_SUB_DIVIDER_SIGNED_EN for two's-complement operands.
module shift_sub_divider #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   busy,
    output logic                   done,
    output logic                   div_by_zero
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  dq_r;
    logic [W-1:0]  dvs_r;

    logic [W-1:0]  dvd_mag;
    logic [W-1:0]  dvs_mag;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;
    logic [W-1:0]  step_rem;
    logic [W-1:0]  step_q;
    logic [W-1:0]  fix_q;
    logic [W-1:0]  fix_r;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign dvd_mag = dividend[W-1] ? -dividend : dividend;
    assign dvs_mag = divisor[W-1]  ? -divisor  : divisor;
    assign fix_q   = q_neg ? -step_q   : step_q;
    assign fix_r   = r_neg ? -step_rem : step_rem;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign fix_q   = step_q;
    assign fix_r   = step_rem;
`endif

    // Partial remainder stays below the divisor, so a set top bit of
    // the shifted value always means the subtraction fits.
    assign shifted  = {rem_r, dq_r[W-1]};
    assign diff     = shifted - {1'b0, dvs_r};
    assign fits     = shifted[W] | ~diff[W];
    assign step_rem = fits ? diff[W-1:0] : shifted[W-1:0];
    assign step_q   = {dq_r[W-2:0], fits};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            dq_r        <= '0;
            dvs_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dq_r  <= dvd_mag;
                            dvs_r <= dvs_mag;
                            rem_r <= '0;
                            cnt   <= CW'(W);
                            state <= RUN;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
                            q_neg <= dividend[W-1] ^ divisor[W-1];
                            r_neg <= dividend[W-1];
`endif
                        end
                    end
                end
                RUN: begin
                    rem_r <= step_rem;
                    dq_r  <= step_q;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient    <= fix_q;
                        remainder   <= fix_r;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed-vector bench for shift_sub_divider, WORD_LENGTH = 8.
// Signed vectors run only when SHIFT_SUB_DIVIDER_SIGNED_EN is defined.
module tb_shift_sub_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    shift_sub_divider #(.WORD_LENGTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int from, output int n);
        n = from;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Starts a division, scrambles inputs after capture, checks result
    // and latency, then steps past DONE back into IDLE.
    task automatic run_div(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input int lat,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic ez);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = ~a;
        divisor  = b ^ 8'h5a;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(1, n);
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk({tag, ".q"}, 32'(quotient), 32'(eq));
        chk({tag, ".r"}, 32'(remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
        tick();
        chk({tag, ".pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        logic saw;

        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd12;
        divisor  = 8'd4;
        tick();
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.q", 32'(quotient), 32'd0);
        chk("rst.r", 32'(remainder), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        run_div("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);

        run_div("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
        run_div("d255_255", 8'd255, 8'd255, 9, 8'd1, 8'd0, 1'b0);
        chk("hold.q", 32'(quotient), 32'd1);

        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, n);
        chk("ign.lat", 32'(n), 32'd9);
        chk("ign.q", 32'(quotient), 32'd14);
        chk("ign.r", 32'(remainder), 32'd2);
        dividend = 8'd3;
        divisor  = 8'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_done.busy", 32'(busy), 32'd0);
        chk("ign_done.q", 32'(quotient), 32'd14);

        run_div("d5_0", 8'd5, 8'd0, 1, 8'hff, 8'd5, 1'b1);

        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.q", 32'(quotient), 32'd0);
        chk("abort.r", 32'(remainder), 32'd0);
        chk("abort.dbz", 32'(div_by_zero), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            saw = saw | done;
        end
        chk("abort.nodone", 32'(saw), 32'd0);

        run_div("d9_3", 8'd9, 8'd3, 9, 8'd3, 8'd0, 1'b0);

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        run_div("sn100_7", 8'h9c, 8'h07, 9, 8'hf2, 8'hfe, 1'b0);
        run_div("sn128_n1", 8'h80, 8'hff, 9, 8'h80, 8'h00, 1'b0);
        run_div("s100_n7", 8'h64, 8'hf9, 9, 8'hf2, 8'h02, 1'b0);
        run_div("sn5_0", 8'hfb, 8'h00, 1, 8'hff, 8'hfb, 1'b1);
`else
        run_div("d200_3", 8'd200, 8'd3, 9, 8'd66, 8'd2, 1'b0);
        run_div("d7_9", 8'd7, 8'd9, 9, 8'd0, 8'd7, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
